// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / LSU) arbiter onto a single memory port with ack timeout.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise the LSU has fixed priority.
module mem_port_arbiter #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    input  logic        i_ls_req,
    input  logic        i_ls_wren,
    input  logic [31:0] i_ls_addr,
    input  logic [31:0] i_ls_wdata,
    input  logic [3:0]  i_ls_strb,
    output logic        o_ls_gnt,
    output logic        o_ls_rvalid,
    output logic [31:0] o_rdata,
    output logic        o_err,
    output logic        o_mem_req,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_strb,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_busy
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] cnt;
    logic       owner_ls;
    logic       pick_ls;
    logic       grant;

`ifdef ARB_RR_EN
    logic       last_ls;

    // On a tie the requester that did not win last time goes first.
    assign pick_ls = i_ls_req && (!i_if_req || !last_ls);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            last_ls <= 1'b0;
        end else if (grant) begin
            last_ls <= pick_ls;
        end
    end
`else
    assign pick_ls = i_ls_req;
`endif

    assign grant       = (state == IDLE) && (i_if_req || i_ls_req);
    assign o_busy      = (state != IDLE);
    assign o_mem_req   = (state == BUSY);
    assign o_if_rvalid = (state == RESP) && !owner_ls;
    assign o_ls_rvalid = (state == RESP) && owner_ls;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_if_gnt  = 1'b0;
        o_ls_gnt  = 1'b0;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = BUSY;
                    o_ls_gnt  = pick_ls;
                    o_if_gnt  = !pick_ls;
                end
            end
            BUSY: begin
                // An ack in the timeout cycle still completes normally.
                if (i_mem_ack || cnt == CNT_LAST) begin
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            cnt         <= 8'd0;
            owner_ls    <= 1'b0;
            o_mem_wren  <= 1'b0;
            o_mem_addr  <= 32'd0;
            o_mem_wdata <= 32'd0;
            o_mem_strb  <= 4'd0;
            o_rdata     <= 32'd0;
            o_err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        cnt      <= 8'd0;
                        owner_ls <= pick_ls;
                        if (pick_ls) begin
                            o_mem_wren  <= i_ls_wren;
                            o_mem_addr  <= i_ls_addr;
                            o_mem_wdata <= i_ls_wdata;
                            o_mem_strb  <= i_ls_strb;
                        end else begin
                            o_mem_wren  <= 1'b0;
                            o_mem_addr  <= i_if_addr;
                            o_mem_wdata <= 32'd0;
                            o_mem_strb  <= 4'hF;
                        end
                    end
                end
                BUSY: begin
                    if (i_mem_ack) begin
                        o_rdata <= o_mem_wren ? 32'd0 : i_mem_rdata;
                        o_err   <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (cnt == CNT_LAST) begin
                            o_rdata <= 32'd0;
                            o_err   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: driver predicts each response, a monitor checks rvalids.
// Honors ARB_RR_EN the same way as the design.
module tb_mem_port_arbiter;

    localparam int TIMEOUT_CYC = 15;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = 32'd0;
    logic        i_ls_req = 1'b0;
    logic        i_ls_wren = 1'b0;
    logic [31:0] i_ls_addr = 32'd0;
    logic [31:0] i_ls_wdata = 32'd0;
    logic [3:0]  i_ls_strb = 4'd0;
    logic [31:0] i_mem_rdata = 32'd0;
    logic        i_mem_ack = 1'b0;
    logic        o_if_gnt, o_if_rvalid, o_ls_gnt, o_ls_rvalid;
    logic [31:0] o_rdata;
    logic        o_err;
    logic        o_mem_req, o_mem_wren;
    logic [31:0] o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_strb;
    logic        o_busy;

    mem_port_arbiter #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_gnt(o_if_gnt), .o_if_rvalid(o_if_rvalid),
        .i_ls_req(i_ls_req), .i_ls_wren(i_ls_wren), .i_ls_addr(i_ls_addr),
        .i_ls_wdata(i_ls_wdata), .i_ls_strb(i_ls_strb),
        .o_ls_gnt(o_ls_gnt), .o_ls_rvalid(o_ls_rvalid),
        .o_rdata(o_rdata), .o_err(o_err),
        .o_mem_req(o_mem_req), .o_mem_wren(o_mem_wren), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_strb(o_mem_strb),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        ls;
        logic [31:0] rdata;
        logic        err;
        int          at;
    } resp_t;

    resp_t sb[$];
    int    checks = 0;
    int    errors = 0;
    logic  last_ls_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arbitration: LSU first, except that round-robin alternates on a tie.
    function automatic logic model_pick_ls(input logic ifr, input logic lsr);
`ifdef ARB_RR_EN
        if (ifr && lsr) return !last_ls_m;
`endif
        return lsr;
    endfunction

    always @(negedge clk) begin
        if (o_if_rvalid || o_ls_rvalid) begin
            resp_t e;
            chk("rvalid_onehot", 32'(o_if_rvalid && o_ls_rvalid), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_owner_ls", 32'(o_ls_rvalid), 32'(e.ls));
                chk("resp_rdata", o_rdata, e.rdata);
                chk("resp_err", 32'(o_err), 32'(e.err));
                chk("resp_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
        i_mem_ack = 1'b0;
    endtask

    // Runs one transaction; requests must already be driven in an IDLE cycle.
    // The memory acks in BUSY cycle d+1; d >= TIMEOUT_CYC means it never acks.
    task automatic do_txn(input int d, input logic [31:0] rd);
        logic        exp_ls, ew;
        logic [31:0] ea, ewd;
        logic [3:0]  es;
        bit          done;
        int          k;
        @(negedge clk);
        if (!(o_if_gnt || o_ls_gnt)) begin
            chk("gnt_in_first_idle_cycle", 32'd0, 32'd1);
            return;
        end
        exp_ls = model_pick_ls(i_if_req, i_ls_req);
        chk("gnt_onehot", 32'(o_if_gnt && o_ls_gnt), 32'd0);
        chk("gnt_winner_ls", 32'(o_ls_gnt), 32'(exp_ls));
        chk("busy_at_gnt", 32'(o_busy), 32'd0);
        if (exp_ls) begin
            ew = i_ls_wren; ea = i_ls_addr; ewd = i_ls_wdata; es = i_ls_strb;
        end else begin
            ew = 1'b0; ea = i_if_addr; ewd = 32'd0; es = 4'hF;
        end
        last_ls_m = exp_ls;
        k = 1;
        done = 1'b0;
        while (!done) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                if (exp_ls) begin
                    i_ls_req = 1'b0; i_ls_addr = $urandom; i_ls_wdata = $urandom;
                    i_ls_strb = 4'($urandom); i_ls_wren = 1'($urandom);
                end else begin
                    i_if_req = 1'b0; i_if_addr = $urandom;
                end
            end
            i_mem_ack = (k == d + 1);
            i_mem_rdata = (k == d + 1) ? rd : $urandom;
            @(negedge clk);
            chk("busy_mem_req", 32'(o_mem_req && o_busy), 32'd1);
            chk("busy_no_gnt", 32'(o_if_gnt || o_ls_gnt), 32'd0);
            chk("mem_addr", o_mem_addr, ea);
            chk("mem_wdata", o_mem_wdata, ewd);
            chk("mem_wren_strb", {27'd0, o_mem_wren, o_mem_strb}, {27'd0, ew, es});
            if (k == d + 1) begin
                sb.push_back('{ls: exp_ls, rdata: (ew ? 32'd0 : rd), err: 1'b0, at: cyc + 1});
                done = 1'b1;
            end else if (k == TIMEOUT_CYC) begin
                sb.push_back('{ls: exp_ls, rdata: 32'd0, err: 1'b1, at: cyc + 1});
                done = 1'b1;
            end
            k++;
        end
        @(posedge clk);
        #1;
        i_mem_ack = 1'($urandom);
        i_mem_rdata = $urandom;
        @(negedge clk);
        chk("resp_busy_no_mem_req", {30'd0, o_busy, o_mem_req}, 32'd2);
        chk("resp_no_gnt", 32'(o_if_gnt || o_ls_gnt), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy_memreq", {30'd0, o_busy, o_mem_req}, 32'd0);
        chk("rst_mem_payload", o_mem_addr | o_mem_wdata | {27'd0, o_mem_wren, o_mem_strb}, 32'd0);
        chk("rst_rdata_err", o_rdata | 32'(o_err), 32'd0);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ctrl", {27'd0, o_if_gnt, o_ls_gnt, o_if_rvalid, o_ls_rvalid, o_busy}, 32'd0);

        // Fetch read with ack two cycles after the first mem_req cycle.
        next_cyc();
        i_if_req = 1'b1; i_if_addr = 32'h100;
        do_txn(2, 32'h00A00093);

        // Simultaneous fetch and LSU write; the held fetch wins right after the LSU RESP.
        next_cyc();
        i_if_req = 1'b1; i_if_addr = 32'h104;
        i_ls_req = 1'b1; i_ls_wren = 1'b1; i_ls_addr = 32'h2000;
        i_ls_wdata = 32'hDEADBEEF; i_ls_strb = 4'b0011;
        do_txn(1, 32'h12345678);
        next_cyc();
        do_txn(0, 32'hCAFEF00D);

        // Pure timeout, then an ack landing in the final BUSY cycle.
        next_cyc();
        i_if_req = 1'b1; i_if_addr = 32'h200;
        do_txn(TIMEOUT_CYC, 32'h11111111);
        next_cyc();
        i_ls_req = 1'b1; i_ls_wren = 1'b0; i_ls_addr = 32'h300;
        i_ls_wdata = 32'h5; i_ls_strb = 4'hF;
        do_txn(TIMEOUT_CYC - 1, 32'h22222222);

        for (int t = 0; t < 150; t++) begin
            next_cyc();
            if (i_if_req) begin
                if ($urandom_range(0, 3) == 0) i_if_req = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                i_if_req = 1'b1; i_if_addr = $urandom;
            end
            if (i_ls_req) begin
                if ($urandom_range(0, 3) == 0) i_ls_req = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                i_ls_req = 1'b1; i_ls_wren = 1'($urandom); i_ls_addr = $urandom;
                i_ls_wdata = $urandom; i_ls_strb = 4'($urandom);
            end
            if (!i_if_req && !i_ls_req) begin
                i_if_req = 1'b1; i_if_addr = $urandom;
            end
            do_txn($urandom_range(0, TIMEOUT_CYC + 2), $urandom);
        end

        // Reset in the middle of BUSY aborts the transaction; a late ack is ignored.
        next_cyc();
        i_if_req = 1'b0;
        i_ls_req = 1'b1; i_ls_wren = 1'b1; i_ls_addr = 32'hABCD0000;
        i_ls_wdata = 32'h0BADF00D; i_ls_strb = 4'hF;
        @(negedge clk);
        chk("abort_gnt_ls", 32'(o_ls_gnt), 32'd1);
        next_cyc();
        i_ls_req = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(o_busy), 32'd1);
        next_cyc();
        i_reset = 1'b0;
        next_cyc();
        i_reset = 1'b1;
        i_mem_ack = 1'b1;
        i_mem_rdata = 32'hFFFFFFFF;
        last_ls_m = 1'b0;
        @(negedge clk);
        chk("abort_ctrl", {27'd0, o_if_gnt, o_ls_gnt, o_if_rvalid, o_ls_rvalid, o_busy}, 32'd0);
        chk("abort_mem", o_mem_addr | o_mem_wdata | {27'd0, o_mem_req, o_mem_wren, o_mem_strb}, 32'd0);
        chk("abort_rdata_err", o_rdata | 32'(o_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("late_ack_idle", 32'(o_busy), 32'd0);
        end

        // Both requesters held for four transactions.
        for (int t = 0; t < 4; t++) begin
            next_cyc();
            i_if_req = 1'b1; i_if_addr = 32'h400 + 32'(t);
            i_ls_req = 1'b1; i_ls_wren = 1'b0; i_ls_addr = 32'h800 + 32'(t);
            i_ls_strb = 4'hF;
            do_txn(t, 32'h33330000 + 32'(t));
        end

        next_cyc();
        i_if_req = 1'b0;
        i_ls_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
